// File: rtl/sync_pulse_sched_pkg.sv
// Shared constants for the sync-pulse scheduler: register map, CTRL/STATUS bit
// positions and the 2-bit FSM state encoding.
package sync_pulse_sched_pkg;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_DELAY  = 3'd1;
    localparam logic [2:0] A_WIDTH  = 3'd2;
    localparam logic [2:0] A_PERIOD = 3'd3;
    localparam logic [2:0] A_COUNT  = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    localparam int CTRL_START    = 0;
    localparam int CTRL_STOP     = 1;
    localparam int CTRL_CLR_DONE = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DLY  = 2'd1,
        S_HI   = 2'd2,
        S_LO   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_pulse_sched_us_down_counter.sv
// Microsecond down-counter: load wins over decrement, decrements on t1us and
// saturates at zero; zero flag is combinational from the count.
module us_down_counter #(
    parameter int CW = 16
) (
    input  logic          clk5mhz,
    input  logic          rst,
    input  logic          t1us,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk5mhz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (t1us && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sync_pulse_sched.sv
// Programmable sync-pulse scheduler: register file, read mux, IDLE/DLY/HI/LO FSM
// and registered sync output. STATUS layout assumes DW >= 16.
module sync_pulse_sched
    import sync_pulse_sched_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk5mhz,
    input  logic          rst,
    input  logic          t1us,
    input  logic [2:0]    adr,
    input  logic [DW-1:0] data,
    input  logic          wr,
    output logic [DW-1:0] rdata,
    output logic          sync_out,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    // Host bus: wr is a single-clock strobe; adr/data are sampled on that clock only.
    state_t        state;
    state_t        next_state;
    logic [DW-1:0] delay_r;
    logic [DW-1:0] width_r;
    logic [DW-1:0] period_r;
    logic [DW-1:0] count_r;
    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] pulse_next;
    logic [CW-1:0] cnt_load_val;
    logic [DW-1:0] w_eff;
    logic [DW-1:0] l_eff;
    logic [DW-1:0] rd_mux;
    logic          cnt_zero;
    logic          cnt_load;
    logic          pulse_clr;
    logic          pulse_inc;
    logic          done_set;
    logic          ctrl_wr;
    logic          start_cmd;
    logic          stop_cmd;
    logic          clr_done_cmd;
    logic          last_pulse;

    assign ctrl_wr      = wr && (adr == A_CTRL);
    assign stop_cmd     = ctrl_wr && data[CTRL_STOP];
    assign start_cmd    = ctrl_wr && data[CTRL_START] && !data[CTRL_STOP];
    assign clr_done_cmd = ctrl_wr && data[CTRL_CLR_DONE];

    // Zero width/period are promoted so every interval lasts at least 1 us.
    assign w_eff      = (width_r == '0) ? DW'(1) : width_r;
    assign l_eff      = (period_r > w_eff) ? (period_r - w_eff) : DW'(1);
    assign pulse_next = pulse_cnt + 1'b1;
    assign last_pulse = (count_r != '0) && (pulse_next == CW'(count_r));

    always_ff @(posedge clk5mhz or posedge rst) begin
        if (rst) begin
            delay_r  <= '0;
            width_r  <= '0;
            period_r <= '0;
            count_r  <= '0;
        end else if (wr) begin
            case (adr)
                A_DELAY:  delay_r  <= data;
                A_WIDTH:  width_r  <= data;
                A_PERIOD: period_r <= data;
                A_COUNT:  count_r  <= data;
                default:  ;
            endcase
        end
    end

    us_down_counter #(
        .CW(CW)
    ) u_cnt (
        .clk5mhz  (clk5mhz),
        .rst      (rst),
        .t1us     (t1us),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk5mhz or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (stop_cmd) begin
            next_state = S_IDLE;
        end else if (start_cmd) begin
            next_state = S_DLY;
        end else begin
            case (state)
                S_IDLE:  next_state = S_IDLE;
                S_DLY:   if (cnt_zero) next_state = S_HI;
                S_HI:    if (cnt_zero) next_state = last_pulse ? S_IDLE : S_LO;
                S_LO:    if (cnt_zero) next_state = S_HI;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Interval lengths are read from the registers only at load time, so host
    // writes during a run never disturb the interval in progress.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        pulse_clr    = 1'b0;
        pulse_inc    = 1'b0;
        done_set     = 1'b0;
        if (!stop_cmd) begin
            if (start_cmd) begin
                cnt_load     = 1'b1;
                cnt_load_val = CW'(delay_r);
                pulse_clr    = 1'b1;
            end else begin
                case (state)
                    S_DLY, S_LO: begin
                        if (cnt_zero) begin
                            cnt_load     = 1'b1;
                            cnt_load_val = CW'(w_eff);
                        end
                    end
                    S_HI: begin
                        if (cnt_zero) begin
                            pulse_inc = 1'b1;
                            if (last_pulse) begin
                                done_set = 1'b1;
                            end else begin
                                cnt_load     = 1'b1;
                                cnt_load_val = CW'(l_eff);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk5mhz or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
            done      <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            if (pulse_clr) begin
                pulse_cnt <= '0;
            end else if (pulse_inc) begin
                pulse_cnt <= pulse_next;
            end
            if (done_set) begin
                done <= 1'b1;
            end else if (start_cmd || clr_done_cmd) begin
                done <= 1'b0;
            end
            sync_out <= (next_state == S_HI);
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_comb begin
        rd_mux = '0;
        case (adr)
            A_DELAY:  rd_mux = delay_r;
            A_WIDTH:  rd_mux = width_r;
            A_PERIOD: rd_mux = period_r;
            A_COUNT:  rd_mux = count_r;
            A_STATUS: begin
                rd_mux[ST_BUSY]                = busy;
                rd_mux[ST_DONE]                = done;
                rd_mux[ST_CNT_LSB+7:ST_CNT_LSB] = pulse_cnt[7:0];
            end
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk5mhz or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rd_mux;
        end
    end

endmodule
